// File: rtl/twiddle_rotator_pkg.sv
// Shared constants for the twiddle rotator: Q-format of the coefficients,
// saturation helpers and the coefficient-table control states.
package twiddle_rotator_pkg;

  localparam int Q_FRAC     = 7;
  localparam int Q_COEF_W   = 9;
  localparam int DEF_N      = 16;
  localparam int DEF_MSB    = 16;
  localparam int DEF_DATA_W = 16;

  typedef enum logic {
    LOAD  = 1'b0,
    READY = 1'b1
  } ctrl_state_t;

  // Largest / smallest two's-complement value representable in w bits.
  function automatic int sat_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sat_min(input int w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/twiddle_rotator_if.sv
// Coefficient-load, sample-in and result-out bundle of the twiddle rotator.
// The master side is the upstream mapper / sample source.
interface twiddle_rotator_if #(
  parameter int N      = 16,
  parameter int MSB    = 16,
  parameter int DATA_W = 16
);
  localparam int AW = $clog2(N / 2);

  logic                     coef_we;
  logic [AW-1:0]            coef_addr;
  logic [MSB-1:0]           c_in;
  logic [MSB-1:0]           cps_in;
  logic [MSB-1:0]           cms_in;
  logic                     coef_done;
  logic                     in_valid;
  logic [AW-1:0]            in_idx;
  logic signed [DATA_W-1:0] in_re;
  logic signed [DATA_W-1:0] in_im;
  logic                     coef_ready;
  logic                     out_valid;
  logic signed [DATA_W-1:0] out_re;
  logic signed [DATA_W-1:0] out_im;
  logic                     err;

  modport master (
    output coef_we, coef_addr, c_in, cps_in, cms_in, coef_done,
    output in_valid, in_idx, in_re, in_im,
    input  coef_ready, out_valid, out_re, out_im, err
  );

  modport slave (
    input  coef_we, coef_addr, c_in, cps_in, cms_in, coef_done,
    input  in_valid, in_idx, in_re, in_im,
    output coef_ready, out_valid, out_re, out_im, err
  );

endinterface

// File: rtl/twiddle_rotator_cmult3.sv
// Three-stage, three-multiplier complex product (a + jb)(c + js) using the
// precomputed c+s / c-s coefficients; floor-scaled by FRAC and saturated.
module cmult3_pipe
  import twiddle_rotator_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int COEF_W = Q_COEF_W,
  parameter int FRAC   = Q_FRAC
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic signed [COEF_W-1:0] c,
  input  logic signed [COEF_W-1:0] cps,
  input  logic signed [COEF_W-1:0] cms,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] re,
  output logic signed [DATA_W-1:0] im
);

  localparam int S_W = DATA_W + 1;
  localparam int P_W = DATA_W + COEF_W + 1;
  localparam int D_W = P_W + 1;
  localparam logic signed [D_W-1:0] MAXV = D_W'(sat_max(DATA_W));
  localparam logic signed [D_W-1:0] MINV = D_W'(sat_min(DATA_W));

  logic                     v1, v2;
  logic signed [S_W-1:0]    s1;
  logic signed [DATA_W-1:0] a1, b1;
  logic signed [COEF_W-1:0] c1, cps1, cms1;
  logic signed [P_W-1:0]    k1, k2, k3;
  logic signed [D_W-1:0]    re_full, im_full, re_sh, im_sh;
  logic signed [DATA_W-1:0] re_sat, im_sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      s1   <= '0;
      a1   <= '0;
      b1   <= '0;
      c1   <= '0;
      cps1 <= '0;
      cms1 <= '0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        s1   <= S_W'(a) + S_W'(b);
        a1   <= a;
        b1   <= b;
        c1   <= c;
        cps1 <= cps;
        cms1 <= cms;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2 <= 1'b0;
      k1 <= '0;
      k2 <= '0;
      k3 <= '0;
    end else begin
      v2 <= v1;
      if (v1) begin
        k1 <= P_W'(c1) * P_W'(s1);
        k2 <= P_W'(b1) * P_W'(cps1);
        k3 <= P_W'(a1) * P_W'(cms1);
      end
    end
  end

  // re = k1 - k2 = ac - bs, im = k1 - k3 = bc + as; >>> gives floor rounding.
  always_comb begin
    re_full = D_W'(k1) - D_W'(k2);
    im_full = D_W'(k1) - D_W'(k3);
    re_sh   = re_full >>> FRAC;
    im_sh   = im_full >>> FRAC;
    re_sat  = re_sh[DATA_W-1:0];
    im_sat  = im_sh[DATA_W-1:0];
    if (re_sh > MAXV)      re_sat = MAXV[DATA_W-1:0];
    else if (re_sh < MINV) re_sat = MINV[DATA_W-1:0];
    if (im_sh > MAXV)      im_sat = MAXV[DATA_W-1:0];
    else if (im_sh < MINV) im_sat = MINV[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      re        <= '0;
      im        <= '0;
    end else begin
      out_valid <= v2;
      if (v2) begin
        re <= re_sat;
        im <= im_sat;
      end
    end
  end

endmodule

// File: rtl/twiddle_rotator.sv
// Captures per-stage twiddle coefficients into local tables and rotates
// lower-leg butterfly samples by W = c + j*s through cmult3_pipe.
module twiddle_rotator
  import twiddle_rotator_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int MSB    = DEF_MSB,
  parameter int COEF_W = Q_COEF_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int FRAC   = Q_FRAC
) (
  input logic              clk,
  input logic              rst_n,
  twiddle_rotator_if.slave bus
);

  localparam int ENTRIES = N / 2;

  ctrl_state_t       state;
  logic              coef_ready;
  logic              err;
  logic              accept;
  logic [COEF_W-1:0] c_mem   [ENTRIES];
  logic [COEF_W-1:0] cps_mem [ENTRIES];
  logic [COEF_W-1:0] cms_mem [ENTRIES];
  logic              unused_coef_hi;

  assign unused_coef_hi = ^{bus.c_in[MSB-1:COEF_W], bus.cps_in[MSB-1:COEF_W],
                            bus.cms_in[MSB-1:COEF_W]};

  // Table writes are never blocked; the FSM only tracks whether it is complete.
  always_ff @(posedge clk) begin
    if (bus.coef_we) begin
      c_mem[bus.coef_addr]   <= bus.c_in[COEF_W-1:0];
      cps_mem[bus.coef_addr] <= bus.cps_in[COEF_W-1:0];
      cms_mem[bus.coef_addr] <= bus.cms_in[COEF_W-1:0];
    end
  end

  // coef_done wins over a simultaneous write so the last write can close the load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LOAD;
      coef_ready <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (bus.coef_done) begin
            state      <= READY;
            coef_ready <= 1'b1;
          end
        end
        READY: begin
          if (!bus.coef_done && bus.coef_we) begin
            state      <= LOAD;
            coef_ready <= 1'b0;
          end
        end
        default: begin
          state      <= LOAD;
          coef_ready <= 1'b0;
        end
      endcase
      if (bus.in_valid && !coef_ready) err <= 1'b1;
    end
  end

  assign accept         = bus.in_valid & coef_ready;
  assign bus.coef_ready = coef_ready;
  assign bus.err        = err;

  cmult3_pipe #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .FRAC   (FRAC)
  ) u_cmult (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (accept),
    .a         (bus.in_re),
    .b         (bus.in_im),
    .c         (c_mem[bus.in_idx]),
    .cps       (cps_mem[bus.in_idx]),
    .cms       (cms_mem[bus.in_idx]),
    .out_valid (bus.out_valid),
    .re        (bus.out_re),
    .im        (bus.out_im)
  );

endmodule

// File: tb/tb_twiddle_rotator.sv
// Directed bench for twiddle_rotator: a reference model of (a+jb)(c+js)
// feeds a scoreboard that is drained whenever out_valid is seen.
module tb_twiddle_rotator;
  import twiddle_rotator_pkg::*;

  localparam int N      = 16;
  localparam int MSB    = 16;
  localparam int DATA_W = 16;

  typedef struct {
    logic signed [15:0] re;
    logic signed [15:0] im;
    int                 cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   c_tab [8];
  int   s_tab [8];
  exp_t sb [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  twiddle_rotator_if #(.N(N), .MSB(MSB), .DATA_W(DATA_W)) bus ();

  twiddle_rotator #(
    .N(N), .MSB(MSB), .COEF_W(9), .DATA_W(DATA_W), .FRAC(7)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic signed [15:0] sat16(input longint v);
    if (v > 32767)  return 16'sh7fff;
    if (v < -32768) return 16'sh8000;
    return 16'(v);
  endfunction

  function automatic exp_t model(input int a, input int b, input int c, input int s);
    exp_t   e;
    longint pr;
    longint pi;
    pr    = longint'(a) * longint'(c) - longint'(b) * longint'(s);
    pi    = longint'(b) * longint'(c) + longint'(a) * longint'(s);
    e.re  = sat16(pr >>> 7);
    e.im  = sat16(pi >>> 7);
    e.cyc = 0;
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                             input logic signed [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic loadCoef(input int idx, input int c, input int s, input bit done);
    bus.coef_we   = 1'b1;
    bus.coef_addr = 3'(idx);
    bus.c_in      = 16'(c);
    bus.cps_in    = 16'(c + s);
    bus.cms_in    = 16'(c - s);
    bus.coef_done = done;
    c_tab[idx]    = c;
    s_tab[idx]    = s;
    tick(1);
    bus.coef_we   = 1'b0;
    bus.coef_done = 1'b0;
  endtask

  task automatic pulseDone();
    bus.coef_done = 1'b1;
    tick(1);
    bus.coef_done = 1'b0;
  endtask

  task automatic applyStimulus(input int idx, input int a, input int b, input bit accept);
    exp_t e;
    bus.in_valid = 1'b1;
    bus.in_idx   = 3'(idx);
    bus.in_re    = 16'(a);
    bus.in_im    = 16'(b);
    if (accept) begin
      e     = model(a, b, c_tab[idx], s_tab[idx]);
      e.cyc = cyc + 3;
      sb.push_back(e);
    end
    tick(1);
    bus.in_valid = 1'b0;
  endtask

  task automatic waitDrain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    checkOutput("drain_pending", sb.size(), 0);
  endtask

  // Every out_valid must match the oldest expectation, on the expected cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && bus.out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_out_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        checkOutput("out_re", bus.out_re, e.re);
        checkOutput("out_im", bus.out_im, e.im);
        checkOutput("out_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    failures++;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n         = 1'b0;
    bus.coef_we   = 1'b0;
    bus.coef_addr = '0;
    bus.c_in      = '0;
    bus.cps_in    = '0;
    bus.cms_in    = '0;
    bus.coef_done = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_idx    = '0;
    bus.in_re     = '0;
    bus.in_im     = '0;
    tick(3);
    checkOutput("rst_coef_ready", bus.coef_ready, 0);
    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkOutput("rst_out_re", bus.out_re, 0);
    checkOutput("rst_out_im", bus.out_im, 0);
    checkOutput("rst_err", bus.err, 0);
    rst_n = 1'b1;
    tick(1);

    $display("[TB] sample before table load is dropped");
    applyStimulus(0, 1, 2, 1'b0);
    checkOutput("err_set", bus.err, 1);
    tick(4);
    checkOutput("dropped_no_out", bus.out_valid, 0);

    $display("[TB] identity load, done with last write");
    for (int i = 0; i < 8; i++) loadCoef(i, 127, 0, i == 7);
    checkOutput("ready_after_load", bus.coef_ready, 1);
    applyStimulus(3, 100, 50, 1'b1);
    waitDrain(10);
    tick(2);
    checkOutput("hold_re", bus.out_re, 99);
    checkOutput("hold_im", bus.out_im, 49);
    checkOutput("hold_valid_low", bus.out_valid, 0);

    $display("[TB] reload while ready, then x j rotation");
    loadCoef(2, 0, 127, 1'b0);
    checkOutput("ready_drop_on_reload", bus.coef_ready, 0);
    applyStimulus(2, 5, 5, 1'b0);
    pulseDone();
    checkOutput("ready_after_done", bus.coef_ready, 1);
    applyStimulus(2, 100, 0, 1'b1);
    waitDrain(10);

    $display("[TB] saturation at both rails");
    loadCoef(5, 127, 127, 1'b1);
    checkOutput("we_done_same_cycle", bus.coef_ready, 1);
    applyStimulus(5, 32767, 32767, 1'b1);
    applyStimulus(5, -32768, -32768, 1'b1);
    waitDrain(10);

    $display("[TB] coefficient rewrite behind an in-flight sample");
    applyStimulus(5, 1000, -2000, 1'b1);
    loadCoef(5, -127, 0, 1'b1);
    waitDrain(10);

    $display("[TB] back-to-back stream over all entries");
    loadCoef(0, 90, 90, 1'b0);
    loadCoef(1, -90, 90, 1'b0);
    loadCoef(4, 0, -127, 1'b0);
    loadCoef(6, 64, -100, 1'b1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(i, int'($urandom_range(0, 65535)) - 32768,
                    int'($urandom_range(0, 65535)) - 32768, 1'b1);
    end
    waitDrain(12);

    $display("[TB] reset with samples in flight");
    applyStimulus(1, 300, -400, 1'b1);
    applyStimulus(6, -500, 600, 1'b1);
    tick(1);
    rst_n = 1'b0;
    sb.delete();
    #1;
    checkOutput("midrst_out_valid", bus.out_valid, 0);
    checkOutput("midrst_coef_ready", bus.coef_ready, 0);
    checkOutput("midrst_err", bus.err, 0);
    checkOutput("midrst_out_re", bus.out_re, 0);
    tick(2);
    rst_n = 1'b1;
    tick(8);
    checkOutput("post_rst_out_valid", bus.out_valid, 0);
    checkOutput("post_rst_ready", bus.coef_ready, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
